// File: rtl/collision_scanner.sv
// ============================================================================
// collision_scanner
// ----------------------------------------------------------------------------
// Sequential ship/asteroid collision check. On an accepted start it reads the
// frame bitmaps one row at a time through a registered row-read port. Each
// ship row is ANDed with the same row of every live asteroid. Any overlap sets
// that asteroid's bit in a sticky hit vector. The lowest row that produced a
// hit is also recorded.
//
// Parameters
//   ROW_W   pixels per bitmap row
//   ROWS    rows per bitmap
//   N_AST   number of asteroid channels
//   ROW_AW  row index width, 2**ROW_AW >= ROWS
//
// Ports
//   clock      single clock, rising edge
//   reset      synchronous, active-high
//   start      scan request, only honoured in IDLE
//   alive      asteroid enable mask, captured on an accepted start
//   rd_en      row read request to the bitmap store
//   rd_row     row index being requested
//   ship_row   ship bitmap row, valid one cycle after its request
//   ast_rows   asteroid rows, asteroid i at [i*ROW_W +: ROW_W], same latency
//   busy       high in every state except IDLE
//   done       one-cycle pulse, results valid from this cycle onward
//   hit_vec    per-asteroid sticky overlap flags
//   ship_hit   OR of hit_vec
//   first_row  lowest row index with any hit, 0 when ship_hit is 0
//
// Configuration
//   COLLISION_EARLY_EXIT_EN  when defined, reading stops as soon as the first
//                            hit is seen. The row already in flight is still
//                            evaluated before done.
// ============================================================================
module collision_scanner #(
   parameter int ROW_W  = 180,
   parameter int ROWS   = 160,
   parameter int N_AST  = 16,
   parameter int ROW_AW = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [N_AST-1:0]        alive,
   output logic                    rd_en,
   output logic [ROW_AW-1:0]       rd_row,
   input  logic [ROW_W-1:0]        ship_row,
   input  logic [N_AST*ROW_W-1:0]  ast_rows,
   output logic                    busy,
   output logic                    done,
   output logic [N_AST-1:0]        hit_vec,
   output logic                    ship_hit,
   output logic [ROW_AW-1:0]       first_row
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

   state_t              state;
   logic [N_AST-1:0]    alive_q;
   logic                eval_v;
   logic [ROW_AW-1:0]   eval_row;
   logic [N_AST-1:0]    row_hits;
   logic                any_hit;
   logic                stop_early;

   // Per-asteroid overlap for the row currently on the read data bus.
   // Dead asteroids are masked here, so they can never reach hit_vec.
   always_comb begin
      row_hits = '0;
      for (int i = 0; i < N_AST; i++) begin
         row_hits[i] = alive_q[i] & (|(ship_row & ast_rows[i*ROW_W +: ROW_W]));
      end
   end

   assign any_hit = |row_hits;

   // With early exit, the first hit on a valid row stops further requests.
   // ship_hit still low means no earlier row has hit yet.
`ifdef COLLISION_EARLY_EXIT_EN
   assign stop_early = eval_v & any_hit & ~ship_hit;
`else
   assign stop_early = 1'b0;
`endif

   // Scan controller and result accumulation.
   // eval_v/eval_row delay the request by one cycle to match the fixed read
   // latency. Data arriving on the bus is only folded in when it answers a
   // real request. Reset clears eval_v, so data already in flight when a scan
   // is abandoned is dropped.
   // first_row is written only while ship_hit is still clear. The earliest
   // hitting row therefore sticks for the rest of the scan.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         alive_q   <= '0;
         eval_v    <= 1'b0;
         eval_row  <= '0;
         rd_en     <= 1'b0;
         rd_row    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit_vec   <= '0;
         ship_hit  <= 1'b0;
         first_row <= '0;
      end else begin
         eval_v   <= rd_en;
         eval_row <= rd_row;

         if (eval_v) begin
            hit_vec  <= hit_vec | row_hits;
            ship_hit <= ship_hit | any_hit;
            if (!ship_hit && any_hit) begin
               first_row <= eval_row;
            end
         end

         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= SCAN;
                  alive_q   <= alive;
                  hit_vec   <= '0;
                  ship_hit  <= 1'b0;
                  first_row <= '0;
                  rd_en     <= 1'b1;
                  rd_row    <= '0;
                  busy      <= 1'b1;
               end
            end

            SCAN: begin
               if (rd_row == LAST_ROW || stop_early) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else begin
                  rd_row <= rd_row + 1'b1;
               end
            end

            DRAIN: begin
               done  <= 1'b1;
               state <= DONE;
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               rd_en <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_collision_scanner.sv
// ============================================================================
// tb_collision_scanner
// ----------------------------------------------------------------------------
// Bench for collision_scanner at default parameters. The bitmap store is a
// pair of arrays behind a one-cycle registered read port. The port returns
// random noise whenever no row is requested. Expected results come from a
// row-by-row reference model that works directly on the arrays.
// ============================================================================
module tb_collision_scanner;

   localparam int ROW_W  = 180;
   localparam int ROWS   = 160;
   localparam int N_AST  = 16;
   localparam int ROW_AW = 8;

   logic                    clock;
   logic                    reset;
   logic                    start;
   logic [N_AST-1:0]        alive;
   logic                    rd_en;
   logic [ROW_AW-1:0]       rd_row;
   logic [ROW_W-1:0]        ship_row;
   logic [N_AST*ROW_W-1:0]  ast_rows;
   logic                    busy;
   logic                    done;
   logic [N_AST-1:0]        hit_vec;
   logic                    ship_hit;
   logic [ROW_AW-1:0]       first_row;

   logic [ROW_W-1:0] ship_mem [ROWS];
   logic [ROW_W-1:0] ast_mem  [ROWS][N_AST];

   int checks = 0;
   int errors = 0;

   collision_scanner #(
      .ROW_W (ROW_W),
      .ROWS  (ROWS),
      .N_AST (N_AST),
      .ROW_AW(ROW_AW)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .alive    (alive),
      .rd_en    (rd_en),
      .rd_row   (rd_row),
      .ship_row (ship_row),
      .ast_rows (ast_rows),
      .busy     (busy),
      .done     (done),
      .hit_vec  (hit_vec),
      .ship_hit (ship_hit),
      .first_row(first_row)
   );

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Random bitmap row used as bus noise.
   function automatic logic [ROW_W-1:0] noise_row();
      logic [ROW_W-1:0] v;
      for (int b = 0; b < ROW_W; b++) v[b] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   // Bitmap store with a fixed one-cycle read latency. When no row is
   // requested it returns noise, so stray evaluation shows up as hits.
   always @(posedge clock) begin
      if (rd_en && int'(rd_row) < ROWS) begin
         ship_row <= ship_mem[rd_row];
         for (int i = 0; i < N_AST; i++) ast_rows[i*ROW_W +: ROW_W] <= ast_mem[rd_row][i];
      end else begin
         ship_row <= noise_row();
         for (int i = 0; i < N_AST; i++) ast_rows[i*ROW_W +: ROW_W] <= noise_row();
      end
   end

   // Hard stop in case the bench itself stalls.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   // Count one comparison and report a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic clear_mem();
      for (int r = 0; r < ROWS; r++) begin
         ship_mem[r] = '0;
         for (int i = 0; i < N_AST; i++) ast_mem[r][i] = '0;
      end
   endtask

   // Reference model. Rows 0..last are scanned, where last is ROWS-1 unless
   // early exit stops after the row following the first hit. done falls at
   // T0+last+3.
   task automatic model(input logic [N_AST-1:0] a, output logic [N_AST-1:0] eh,
                        output int efirst, output int elast);
      bit found = 0;
      eh = '0;
      efirst = 0;
      elast = ROWS - 1;
      for (int r = 0; r < ROWS; r++) begin
         if (r <= elast) begin
            for (int i = 0; i < N_AST; i++) begin
               if (a[i] && ((ship_mem[r] & ast_mem[r][i]) != '0)) begin
                  eh[i] = 1'b1;
                  if (!found) begin
                     found = 1;
                     efirst = r;
`ifdef COLLISION_EARLY_EXIT_EN
                     elast = (r + 1 < ROWS) ? r + 1 : ROWS - 1;
`endif
                  end
               end
            end
         end
      end
   endtask

   // Run one full scan and compare against the model.
   // extra_start_at >= 1 raises start in cycle T0+k. -2 selects the done cycle.
   task automatic applyStimulus(input string tag, input logic [N_AST-1:0] a, input int extra_start_at);
      logic [N_AST-1:0] eh;
      int efirst, elast, lat, xs;
      int done_k, done_cnt, bad_busy, bad_rd, max_row;
      model(a, eh, efirst, elast);
      lat = elast + 3;
      xs = (extra_start_at == -2) ? lat : extra_start_at;
      done_k = -1; done_cnt = 0; bad_busy = 0; bad_rd = 0; max_row = 0;

      @(negedge clock);
      start = 1'b1;
      alive = a;
      @(posedge clock);
      #1;
      start = 1'b0;
      alive = N_AST'($urandom);
      for (int k = 1; k <= lat + 3; k++) begin
         @(negedge clock);
         start = (k == xs);
         if (busy !== (k <= lat)) bad_busy++;
         if (rd_en !== (k <= elast + 1)) bad_rd++;
         else if (rd_en && int'(rd_row) != k - 1) bad_rd++;
         if (rd_en && int'(rd_row) > max_row) max_row = int'(rd_row);
         if (done === 1'b1) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
      end
      start = 1'b0;

      checkOutput({tag, " done_latency"}, 64'(done_k), 64'(lat));
      checkOutput({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
      checkOutput({tag, " busy_pattern_errs"}, 64'(bad_busy), 64'd0);
      checkOutput({tag, " rd_pattern_errs"}, 64'(bad_rd), 64'd0);
      checkOutput({tag, " max_rd_row"}, 64'(max_row), 64'(elast));
      checkOutput({tag, " hit_vec"}, 64'(hit_vec), 64'(eh));
      checkOutput({tag, " ship_hit"}, 64'(ship_hit), 64'(|eh));
      checkOutput({tag, " first_row"}, 64'(first_row), 64'(efirst));
   endtask

   // Start a scan, reset it in cycle T0+reset_at, and confirm it is abandoned.
   task automatic run_reset(input string tag, input logic [N_AST-1:0] a, input int reset_at);
      int done_cnt = 0;
      int busy_cnt = 0;
      @(negedge clock);
      start = 1'b1;
      alive = a;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int k = 1; k <= reset_at; k++) @(negedge clock);
      checkOutput({tag, " partial_hit_before_reset"}, 64'(ship_hit), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      checkOutput({tag, " rd_en"}, 64'(rd_en), 64'd0);
      checkOutput({tag, " rd_row"}, 64'(rd_row), 64'd0);
      checkOutput({tag, " busy"}, 64'(busy), 64'd0);
      checkOutput({tag, " done"}, 64'(done), 64'd0);
      checkOutput({tag, " hit_vec"}, 64'(hit_vec), 64'd0);
      checkOutput({tag, " ship_hit"}, 64'(ship_hit), 64'd0);
      checkOutput({tag, " first_row"}, 64'(first_row), 64'd0);
      reset = 1'b0;
      for (int k = 0; k < ROWS + 10; k++) begin
         @(negedge clock);
         if (done === 1'b1) done_cnt++;
         if (busy === 1'b1) busy_cnt++;
      end
      checkOutput({tag, " no_done_after_reset"}, 64'(done_cnt), 64'd0);
      checkOutput({tag, " idle_after_reset"}, 64'(busy_cnt), 64'd0);
   endtask

   // Two overlaps: asteroid 3 at row 40 and asteroid 9 at row 100.
   // Near misses on other asteroids sit in the same rows.
   task automatic setup_two_hit();
      clear_mem();
      ship_mem[40][5] = 1'b1;
      ast_mem[40][3][5] = 1'b1;
      ast_mem[40][4][6] = 1'b1;
      ship_mem[100][170] = 1'b1;
      ast_mem[100][9][170] = 1'b1;
      ast_mem[100][10][169] = 1'b1;
   endtask

   // Sparse random bitmaps plus one to three forced overlaps.
   task automatic setup_random();
      int n, r, i, b;
      clear_mem();
      for (int rr = 0; rr < ROWS; rr++) begin
         if ($urandom_range(0, 3) == 0) ship_mem[rr][$urandom_range(0, ROW_W - 1)] = 1'b1;
         for (int ii = 0; ii < N_AST; ii++)
            if ($urandom_range(0, 7) == 0) ast_mem[rr][ii][$urandom_range(0, ROW_W - 1)] = 1'b1;
      end
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
         r = $urandom_range(0, ROWS - 1);
         i = $urandom_range(0, N_AST - 1);
         b = $urandom_range(0, ROW_W - 1);
         ship_mem[r][b] = 1'b1;
         ast_mem[r][i][b] = 1'b1;
      end
   endtask

   initial begin
      int xs;
      reset = 1'b1;
      start = 1'b0;
      alive = '0;
      clear_mem();
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset rd_en", 64'(rd_en), 64'd0);
      checkOutput("reset rd_row", 64'(rd_row), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset hit_vec", 64'(hit_vec), 64'd0);
      checkOutput("reset ship_hit", 64'(ship_hit), 64'd0);
      checkOutput("reset first_row", 64'(first_row), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // No overlap: ship 0x3 at rows 10..12, asteroids elsewhere.
      clear_mem();
      for (int r = 10; r <= 12; r++) ship_mem[r][1:0] = 2'b11;
      for (int i = 0; i < N_AST; i++) begin
         ast_mem[20 + i][i][1:0] = 2'b11;
         ast_mem[10][i][3:2] = 2'b11;
      end
      applyStimulus("no_overlap", 16'hFFFF, -1);

      setup_two_hit();
      applyStimulus("two_hit", 16'hFFFF, -1);
      applyStimulus("alive_mask", 16'hFFF7, -1);
      applyStimulus("start_while_busy", 16'hFFFF, 50);
      applyStimulus("start_in_done", 16'hFFFF, -2);

      run_reset("reset_mid_scan", 16'hFFFF, 80);
      applyStimulus("after_reset", 16'hFFFF, -1);

      // Boundary: the only overlap is on the last row, asteroid 15.
      clear_mem();
      ship_mem[ROWS-1][ROW_W-1] = 1'b1;
      ast_mem[ROWS-1][15][ROW_W-1] = 1'b1;
      ast_mem[ROWS-1][14][0] = 1'b1;
      applyStimulus("last_row", 16'hFFFF, -1);

      for (int t = 0; t < 6; t++) begin
         setup_random();
         case ($urandom_range(0, 2))
            0:       xs = -1;
            1:       xs = $urandom_range(1, 40);
            default: xs = -2;
         endcase
         applyStimulus($sformatf("random%0d", t), N_AST'($urandom), xs);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/collision_scanner.md
# collision_scanner

Parametrised, sequential successor to the combinational ship/asteroid hit checks. On `start` it walks the frame bitmaps one row at a time over a registered row-read port. Each ship row is ANDed against the same row of every asteroid, and the per-asteroid hits accumulate into a sticky vector. It sits between the frame-bitmap store and the game-state logic, which consumes `hit_vec`, `ship_hit` and `first_row` on `done`.

## Interface
Parameters:
- `ROW_W`, 180: pixels per bitmap row.
- `ROWS`, 160: rows per bitmap.
- `N_AST`, 16: asteroid channels.
- `ROW_AW`, 8: row index width; must satisfy 2^ROW_AW ≥ ROWS.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a scan; sampled only in IDLE.
- `alive` in N_AST: asteroid enable mask, latched on an accepted start.
- `rd_en` out 1: row read request.
- `rd_row` out ROW_AW: row index requested.
- `ship_row` in ROW_W: ship bitmap row; valid the cycle after its request.
- `ast_rows` in N_AST*ROW_W: asteroid i occupies bits [i*ROW_W +: ROW_W]; valid the cycle after its request.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; results valid from this cycle on.
- `hit_vec` out N_AST: bit i is set if asteroid i overlaps the ship in any scanned row.
- `ship_hit` out 1: OR-reduction of `hit_vec`.
- `first_row` out ROW_AW: lowest row index with any hit; 0 if `ship_hit` is 0.

## Operation
- FSM states are IDLE, SCAN, DRAIN and DONE.
- IDLE to SCAN on `start`:
  - latch `alive`
  - clear `hit_vec` and `first_row`
  - register `rd_en`=1, `rd_row`=0
- SCAN:
  - `rd_row` increments each cycle.
  - Data for the previous request is evaluated each cycle.
  - After `rd_row`=ROWS-1 is issued, go to DRAIN with `rd_en`=0.
- DRAIN evaluates the final in-flight row, then goes to DONE.
- DONE pulses `done` for one cycle, then returns to IDLE.
- Evaluation per row: `hit_vec[i]` |= alive_q[i] & |(ship_row & ast_rows[i]).
  - Dead asteroids never set a bit.
  - `first_row` takes the row index of the first evaluated row producing any new hit and is never overwritten.
- `start` outside IDLE is ignored, with no queueing.
- `start` high in the DONE cycle is ignored; `start` in the following IDLE cycle is accepted.
- `hit_vec`, `ship_hit` and `first_row` hold their values from `done` until the next accepted start clears them. During a scan they show the partial accumulation and are not valid until `done`.
- Reset value of every output is 0; FSM returns to IDLE.
- Reset mid-scan:
  - abandon the scan
  - drop `rd_en` after the reset edge
  - ignore read data that was already in flight
  - emit no `done`
- `rd_row` never exceeds ROWS-1 and does not wrap.

## Timing
- Accepted start edge is T0.
- Row r is requested during cycle T0+1+r; its data is present and evaluated during T0+2+r.
- `done` is high during T0+ROWS+2, giving a latency of ROWS+2 (162 at defaults).
- `busy` is high from T0+1 through the `done` cycle inclusive.
- Read port contract is fixed one-cycle latency; there is no backpressure.

## Configuration
- `COLLISION_EARLY_EXIT_EN` defined:
  - When the row evaluated in cycle T0+2+r produces the first hit, `rd_en` drops at that edge.
  - The already-requested row r+1 is still evaluated in DRAIN.
  - `done` is high in T0+r+4.
  - `hit_vec` then reflects rows 0..r+1 only.
- `COLLISION_EARLY_EXIT_EN` undefined: all ROWS rows are always scanned, with fixed latency ROWS+2.

## Test plan
- No overlap: ship row 0x3 at rows 10..12, asteroids elsewhere, alive=0xFFFF. Expect `done` at T0+162, `hit_vec`=0, `ship_hit`=0, `first_row`=0.
- Two hits: asteroid 3 overlaps at row 40 and asteroid 9 at row 100. Expect `hit_vec`=0x0208, `ship_hit`=1, `first_row`=40.
- Alive masking: same as the two-hit case with alive=0xFFF7. Expect `hit_vec`=0x0200, `first_row`=100.
- Early exit (macro defined): same as the two-hit case. Expect `rd_en` low after the row-41 request, `done` at T0+44, `hit_vec`=0x0008, `first_row`=40. Same stimulus without the macro gives `done` at T0+162.
- Busy and reset:
  - `start` pulsed at T0+50 is ignored, with a single `done` at T0+162.
  - Asserting `reset` at T0+80 gives `rd_en`=0 and all outputs 0 from T0+81, and no `done`.
  - A new start then scans normally.
- Boundary row: overlap only at row 159 (ROWS-1) on asteroid 15. Expect `hit_vec`=0x8000, `first_row`=159, and `rd_row` never exceeds 159.
